// File: rtl/fifo_package.sv
// Shared constants and types for the FIFO and its write-side arbiter.
package fifo_package;

    localparam int DATA_WIDTH   = 8;
    localparam int FIFO_DEPTH   = 8;
    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_MAX_BURST = 2;

    typedef logic [$clog2(ARB_NUM_REQ)-1:0] req_id_t;

    // Next requester id in round-robin order, wrapping n-1 -> 0.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Rotate-priority picker: first set bit of valid at or after ptr, modulo NUM_REQ.
module fifo_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDW = $clog2(NUM_REQ);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            automatic int j = (int'(ptr) + k) % NUM_REQ;
            if (!any && valid[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts and a credit copy of FIFO fill level.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_package::ARB_NUM_REQ,
    parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_package::FIFO_DEPTH,
    parameter int MAX_BURST  = fifo_package::ARB_MAX_BURST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    input  logic                            fifo_rd_en,
    input  logic                            fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy,
    output logic                            overflow_err
);

    import fifo_package::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int OCW = $clog2(FIFO_DEPTH+1);
    localparam int BCW = $clog2(MAX_BURST+1);

    logic [IDW-1:0]     rr_ptr;
    logic [BCW-1:0]     burst_cnt;
    logic [OCW-1:0]     occ;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               hold;
    logic               have;
    logic               space;
    logic               xfer;
    logic               rd_dec;
    logic [IDW-1:0]     win;
    logic [BCW-1:0]     burst_nxt;

    fifo_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Credit check ignores a same-cycle read so the count can never run ahead of the FIFO.
    always_comb begin
        hold      = (burst_cnt != '0) && req_valid[grant_id] && (burst_cnt < BCW'(MAX_BURST));
        win       = hold ? grant_id : pick_idx;
        have      = hold || pick_any;
        space     = (int'(occ) + int'(fifo_wr_en) + 1) <= FIFO_DEPTH;
        xfer      = have && space;
        rd_dec    = fifo_rd_en && (occ != '0);
        burst_nxt = (win == grant_id) ? burst_cnt + BCW'(1) : BCW'(1);
        req_ready = '0;
        if (xfer)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            occ          <= '0;
            overflow_err <= 1'b0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer) begin
                fifo_din <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
                grant_id <= win;
                if (burst_nxt == BCW'(MAX_BURST)) begin
                    rr_ptr    <= IDW'(rr_next(int'(win), NUM_REQ));
                    burst_cnt <= '0;
                end else begin
                    rr_ptr    <= win;
                    burst_cnt <= burst_nxt;
                end
            end else begin
                burst_cnt <= '0;
            end

            if (fifo_wr_en && !rd_dec) begin
                if (occ == OCW'(FIFO_DEPTH))
                    overflow_err <= 1'b1;
                else
                    occ <= occ + OCW'(1);
            end else if (!fifo_wr_en && rd_dec) begin
                occ <= occ - OCW'(1);
            end

            if (fifo_wr_en && fifo_full)
                overflow_err <= 1'b1;
        end
    end

    assign occupancy = occ;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MB    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            fifo_rd_en = 1'b0;
    logic            fifo_full = 1'b0;
    logic [1:0]      grant_id;
    logic [3:0]      occupancy;
    logic            overflow_err;

    int n_checks = 0;
    int n_fail   = 0;
    int hs;
    int cnt;
    int seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    // Model state: round-robin pointer, burst length, last grantee, fill level, pending write.
    int         m_rr, m_burst, m_gid, m_occ, m_err;
    logic       m_wr;
    logic [7:0] m_din;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_burst = 0; m_gid = 0; m_occ = 0; m_err = 0;
        m_wr = 1'b0; m_din = '0;
    endtask

    function automatic int model_pick();
        if (m_burst > 0 && m_burst < MB && req_valid[m_gid])
            return m_gid;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_rr + k) % N])
                return (m_rr + k) % N;
        return -1;
    endfunction

    // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
    task automatic cycle();
        int         w, n_occ, n_err, n_burst, n_rr, n_gid;
        logic       sp, rd_ok, n_wr;
        logic [7:0] n_din;
        logic [N-1:0] er;
        #1;
        w  = model_pick();
        sp = (m_occ + int'(m_wr) + 1) <= DEPTH;
        er = '0;
        if (w >= 0 && sp) er[w] = 1'b1;
        chk("req_ready",    32'(req_ready),    32'(er));
        chk("fifo_wr_en",   32'(fifo_wr_en),   32'(m_wr));
        chk("fifo_din",     32'(fifo_din),     32'(m_din));
        chk("grant_id",     32'(grant_id),     32'(m_gid));
        chk("occupancy",    32'(occupancy),    32'(m_occ));
        chk("overflow_err", 32'(overflow_err), 32'(m_err));
        hs = (|(req_valid & req_ready)) ? 1 : 0;

        rd_ok = fifo_rd_en && (m_occ > 0);
        n_occ = m_occ;
        n_err = m_err;
        if (m_wr && !rd_ok) begin
            if (m_occ == DEPTH) n_err = 1; else n_occ = m_occ + 1;
        end else if (!m_wr && rd_ok) begin
            n_occ = m_occ - 1;
        end
        if (m_wr && fifo_full) n_err = 1;
        n_wr = (w >= 0 && sp);
        n_din = m_din; n_gid = m_gid; n_rr = m_rr; n_burst = 0;
        if (n_wr) begin
            n_din   = req_data[w*DW +: DW];
            n_gid   = w;
            n_burst = (w == m_gid) ? m_burst + 1 : 1;
            if (n_burst == MB) begin
                n_rr = (w + 1) % N; n_burst = 0;
            end else begin
                n_rr = w;
            end
        end
        @(posedge clk);
        m_occ = n_occ; m_err = n_err; m_wr = n_wr; m_din = n_din;
        m_gid = n_gid; m_rr = n_rr; m_burst = n_burst;
        #1;
    endtask

    // Asserts reset between edges so the clear is seen as asynchronous.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en),   32'h0);
        chk("rst_din",   32'(fifo_din),     32'h0);
        chk("rst_gid",   32'(grant_id),     32'h0);
        chk("rst_occ",   32'(occupancy),    32'h0);
        chk("rst_err",   32'(overflow_err), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Burst-of-two round robin with all requesters active.
        req_valid = 4'hF; fifo_rd_en = 1'b1;
        #1;
        chk("t1_first_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t1_gid",   32'(grant_id),   32'(seq[i]));
            chk("t1_din",   32'(fifo_din),   32'(8'hA0 + 8'(seq[i])));
            chk("t1_wr_en", 32'(fifo_wr_en), 32'h1);
        end

        // Fill to depth without reads, then one read frees exactly one slot.
        apply_reset();
        req_valid = 4'hF; fifo_rd_en = 1'b0;
        cnt = 0;
        repeat (12) begin cycle(); cnt += hs; end
        chk("t2_writes", 32'(cnt), 32'd8);
        chk("t2_ready",  32'(req_ready), 32'h0);
        chk("t2_occ",    32'(occupancy), 32'd8);
        fifo_rd_en = 1'b1;
        cycle();
        fifo_rd_en = 1'b0;
        cnt = 0;
        repeat (4) begin cycle(); cnt += hs; end
        chk("t2_extra_write", 32'(cnt), 32'd1);
        chk("t2_err",         32'(overflow_err), 32'h0);

        // Simultaneous write and read at occupancy 5, then read while empty.
        apply_reset();
        req_valid = 4'h1;
        for (int i = 0; i < 20 && !(m_occ == 5 && m_wr); i++) cycle();
        chk("t3_reach_occ5", 32'(occupancy), 32'd5);
        fifo_rd_en = 1'b1; req_valid = '0;
        cycle();
        chk("t3_occ_wr_rd", 32'(occupancy), 32'd5);
        for (int i = 0; i < 20 && m_occ != 0; i++) cycle();
        cycle();
        chk("t3_occ_empty_rd", 32'(occupancy), 32'd0);
        fifo_rd_en = 1'b0;

        // Single requester is re-granted across burst boundaries without bubbles.
        apply_reset();
        req_valid = 4'b0100; fifo_rd_en = 1'b1;
        repeat (6) begin
            cycle();
            chk("t4_gid",   32'(grant_id),   32'd2);
            chk("t4_wr_en", 32'(fifo_wr_en), 32'h1);
        end

        // Random traffic with a realistic full flag derived from the model's fill level.
        apply_reset();
        repeat (300) begin
            req_valid  = N'($urandom);
            req_data   = (N*DW)'($urandom);
            fifo_rd_en = 1'($urandom_range(0, 1));
            fifo_full  = (m_occ == DEPTH);
            cycle();
        end
        fifo_full = 1'b0;
        chk("rand_no_err", 32'(overflow_err), 32'h0);

        // Full flag asserted while a write is in flight latches the sticky error.
        req_valid = 4'hF; fifo_rd_en = 1'b1;
        for (int i = 0; i < 10 && !m_wr; i++) cycle();
        fifo_full = 1'b1;
        cycle();
        fifo_full = 1'b0;
        repeat (4) cycle();
        chk("t6_sticky_err", 32'(overflow_err), 32'h1);

        // Reset in the middle of a burst with a write pending.
        for (int i = 0; i < 10 && !m_wr; i++) cycle();
        chk("t5_wr_pending", 32'(fifo_wr_en), 32'h1);
        apply_reset();
        #1;
        chk("t5_ready_id0", 32'(req_ready), 32'h1);
        cycle();
        chk("t5_gid0", 32'(grant_id),     32'd0);
        chk("t5_err",  32'(overflow_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the synchronous FIFO between NUM_REQ valid/ready requesters.
- Keeps a credit-based copy of FIFO occupancy, so it never issues a write the FIFO cannot accept.
- Registers the FIFO write port, giving one cycle of latency.
- Sits between producer agents/blocks and the FIFO's wr_en/din/full pins, and monitors rd_en.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, fifo_package::DATA_WIDTH, payload width.
- FIFO_DEPTH, fifo_package::FIFO_DEPTH, entries in the downstream FIFO.
- MAX_BURST, 2, maximum consecutive grants to one requester while others wait (1 = strict round-robin).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has data.
- req_data  input  NUM_REQ*DATA_WIDTH  payload i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; transfer when req_valid[i] && req_ready[i].
- fifo_wr_en  output  1  registered FIFO write strobe.
- fifo_din  output  DATA_WIDTH  registered FIFO write data.
- fifo_rd_en  input  1  FIFO read strobe, monitored only.
- fifo_full  input  1  FIFO full flag, checked only.
- grant_id  output  $clog2(NUM_REQ)  id of the last accepted requester.
- occupancy  output  $clog2(FIFO_DEPTH+1)  tracked FIFO fill level.
- overflow_err  output  1  sticky error flag.

Behaviour:
Reset (asynchronous, active-high):
- All outputs clear to 0: fifo_wr_en, fifo_din, grant_id, occupancy, overflow_err.
- rr_ptr=0, burst_cnt=0.
- An in-flight write is dropped; no partial transfer survives reset.

Occupancy tracking:
- occ increments when fifo_wr_en=1.
- occ decrements when fifo_rd_en=1 and occ!=0. A read while occ==0 is ignored, matching FIFO behaviour.
- A write and a read in the same cycle leave occ unchanged.
- occ saturates at FIFO_DEPTH and never wraps.

Space check:
- space = (occ + fifo_wr_en + 1 <= FIFO_DEPTH).
- Reads in the current cycle are conservatively not credited.

Arbitration (combinational pick from registered state):
- Search order starts at rr_ptr, modulo NUM_REQ.
- If burst_cnt>0, the previous grantee still has req_valid, and burst_cnt<MAX_BURST, the previous grantee keeps the grant.
- Otherwise the first valid requester at or after rr_ptr wins.
- req_ready[w]=space for the winner w; all other req_ready bits are 0.
- No valid requester: req_ready=0.

On a transfer (winner w):
- Next cycle: fifo_wr_en=1, fifo_din=req_data[w], grant_id=w.
- If w equals the previous grantee, burst_cnt increments; otherwise burst_cnt=1.
- If burst_cnt reaches MAX_BURST, rr_ptr=w+1 (wrapping NUM_REQ-1 -> 0) and burst_cnt=0. Otherwise rr_ptr=w.

No transfer:
- fifo_wr_en=0 next cycle; fifo_din holds its value.
- burst_cnt=0 and rr_ptr unchanged.

Throughput and latency:
- One write per cycle while space holds.
- Latency from req handshake to fifo_wr_en is exactly 1 cycle.

Errors:
- overflow_err sets on fifo_wr_en && fifo_full.
- overflow_err also sets if occ would exceed FIFO_DEPTH.
- It clears only on reset. Any set is a design bug.

Requester rules:
- req_data must be stable while req_valid is high and not accepted.
- Dropping req_valid without a transfer is legal.

Decomposition:
- fifo_package gains FIFO_DEPTH (localparam), ARB_NUM_REQ default, and typedef req_id_t = logic [$clog2(ARB_NUM_REQ)-1:0].
- Sub-module fifo_rr_picker: combinational rotate-priority picker. Inputs are valid vector and start pointer; outputs are one-hot grant and grant index.
- All state lives in fifo_wr_arbiter.

Test Plan:
1. Reset with all req_valid=1, then release: first grant goes to id 0, then 0,0,1,1,2,2,3,3 (MAX_BURST=2). fifo_wr_en is high every cycle, fifo_din tracks the winner's data one cycle later.
2. Fill with FIFO_DEPTH=8 and no reads: exactly 8 writes, then req_ready=0 and occupancy=8. Pulse fifo_rd_en once: exactly one more write, and overflow_err stays 0.
3. Simultaneous fifo_wr_en and fifo_rd_en at occ=5: occupancy stays 5. fifo_rd_en at occ=0: occupancy stays 0.
4. Only req 2 valid, MAX_BURST=2: it is granted on consecutive cycles (burst_cnt 1 -> 2 -> rr_ptr=3 -> re-picked). No bubbles; grant_id=2 throughout.
5. Assert rst mid-burst with fifo_wr_en=1: all outputs are 0 asynchronously. After release, occupancy=0 and arbitration restarts at id 0.
6. Force fifo_full=1 while fifo_wr_en=1: overflow_err=1 and stays set until the next rst.
